// File: rtl/filter_ctrl_master.sv
// filter_ctrl_master: AXI4-Lite initiator that runs the image filter control
// sequence (poll IDLE, load kernel, start, poll DONE, stop) without a host.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, kernel         run request; 27-bit {W9..W1} kernel sampled on accept
//   busy, done, error     sequence in progress / completion pulse / sticky fault
//   last_status           last STATUS word read
//   m_axi_control_*       AXI4-Lite master to the filter's s_axi_control port
module filter_ctrl_master #(
    parameter int AXI_CONTROL_DATA_WIDTH = 32,
    parameter int AXI_CONTROL_ADDR_WIDTH = 2,
    parameter int POLL_GAP               = 4,
    parameter int MAX_POLLS              = 1048576
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [26:0]                       kernel,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [AXI_CONTROL_DATA_WIDTH-1:0] last_status,
    output logic [AXI_CONTROL_ADDR_WIDTH-1:0] m_axi_control_awaddr,
    output logic                              m_axi_control_awvalid,
    input  logic                              m_axi_control_awready,
    output logic [AXI_CONTROL_DATA_WIDTH-1:0] m_axi_control_wdata,
    output logic                              m_axi_control_wvalid,
    input  logic                              m_axi_control_wready,
    input  logic [1:0]                        m_axi_control_bresp,
    input  logic                              m_axi_control_bvalid,
    output logic                              m_axi_control_bready,
    output logic [AXI_CONTROL_ADDR_WIDTH-1:0] m_axi_control_araddr,
    output logic                              m_axi_control_arvalid,
    input  logic                              m_axi_control_arready,
    input  logic [AXI_CONTROL_DATA_WIDTH-1:0] m_axi_control_rdata,
    input  logic [1:0]                        m_axi_control_rresp,
    input  logic                              m_axi_control_rvalid,
    output logic                              m_axi_control_rready
);

    localparam int DW = AXI_CONTROL_DATA_WIDTH;
    localparam int AW = AXI_CONTROL_ADDR_WIDTH;
    localparam int PW = (MAX_POLLS > 0) ? $clog2(MAX_POLLS + 1) : 1;
    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_POLL_IDLE, S_WR_FILTER, S_WR_START,
        S_POLL_DONE, S_WR_STOP, S_FINISH
    } state_t;

    // GAP doubles as "issue next transaction" once gap_q has run down to 0.
    typedef enum logic [1:0] { PH_GAP, PH_ADDR, PH_RESP } phase_t;

    state_t          state_q;
    phase_t          ph_q;
    logic [GW-1:0]   gap_q;
    logic [PW-1:0]   polls_q;
    logic [26:0]     kernel_q;
    logic            busy_q, done_q, error_q;
    logic [DW-1:0]   status_q;
    logic [AW-1:0]   awaddr_q, araddr_q;
    logic [DW-1:0]   wdata_q;
    logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic            aw_done_q, w_done_q;

    logic            is_poll, is_wr, rd_hs, poll_miss, go, aw_hs, w_hs;
    logic [DW-1:0]   target;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;

    always_comb begin
        is_poll   = (state_q == S_POLL_IDLE) || (state_q == S_POLL_DONE);
        is_wr     = (state_q == S_WR_FILTER) || (state_q == S_WR_START) ||
                    (state_q == S_WR_STOP);
        target    = (state_q == S_POLL_DONE) ? DW'(2) : '0;
        rd_hs     = rready_q & m_axi_control_rvalid;
        aw_hs     = awvalid_q & m_axi_control_awready;
        w_hs      = wvalid_q & m_axi_control_wready;
        poll_miss = is_poll && (ph_q == PH_RESP) && rd_hs &&
                    (m_axi_control_rresp == 2'b00) &&
                    (m_axi_control_rdata != target);
        // With no poll gap a missed poll re-reads on the very next edge.
        go        = ((ph_q == PH_GAP) && (gap_q == '0) && (is_poll || is_wr)) ||
                    (poll_miss && (POLL_GAP == 0));
        wr_addr   = (state_q == S_WR_FILTER) ? AW'(2) : '0;
        wr_data   = '0;
        if (state_q == S_WR_FILTER) begin
            wr_data[26:0] = kernel_q;
        end else if (state_q == S_WR_START) begin
            wr_data = DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ph_q      <= PH_GAP;
            gap_q     <= '0;
            polls_q   <= '0;
            kernel_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            status_q  <= '0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        kernel_q <= kernel;
                        error_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        polls_q  <= '0;
                        gap_q    <= '0;
                        ph_q     <= PH_GAP;
                        state_q  <= S_POLL_IDLE;
                    end
                end
                S_POLL_IDLE, S_POLL_DONE: begin
                    unique case (ph_q)
                        PH_GAP: begin
                            if (gap_q != '0) gap_q <= gap_q - 1'b1;
                        end
                        PH_ADDR: begin
                            if (m_axi_control_arready) begin
                                arvalid_q <= 1'b0;
                                rready_q  <= 1'b1;
                                ph_q      <= PH_RESP;
                            end
                        end
                        PH_RESP: begin
                            if (rd_hs) begin
                                rready_q <= 1'b0;
                                status_q <= m_axi_control_rdata;
                                if (m_axi_control_rresp != 2'b00) begin
                                    state_q <= S_IDLE;
                                    ph_q    <= PH_GAP;
                                    busy_q  <= 1'b0;
                                    error_q <= 1'b1;
                                end else if (m_axi_control_rdata == target) begin
                                    state_q <= (state_q == S_POLL_IDLE) ? S_WR_FILTER
                                                                        : S_WR_STOP;
                                    ph_q    <= PH_GAP;
                                    gap_q   <= '0;
                                    polls_q <= '0;
                                end else begin
                                    ph_q  <= PH_GAP;
                                    gap_q <= GAP_RELOAD;
                                end
                            end
                        end
                        default: ph_q <= PH_GAP;
                    endcase
                end
                S_WR_FILTER, S_WR_START, S_WR_STOP: begin
                    unique case (ph_q)
                        PH_GAP: ;
                        PH_ADDR: begin
                            if (aw_hs) begin
                                awvalid_q <= 1'b0;
                                aw_done_q <= 1'b1;
                            end
                            if (w_hs) begin
                                wvalid_q <= 1'b0;
                                w_done_q <= 1'b1;
                            end
                            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                                bready_q <= 1'b1;
                                ph_q     <= PH_RESP;
                            end
                        end
                        PH_RESP: begin
                            if (m_axi_control_bvalid) begin
                                bready_q <= 1'b0;
                                ph_q     <= PH_GAP;
                                gap_q    <= '0;
                                if (m_axi_control_bresp != 2'b00) begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                    error_q <= 1'b1;
                                end else if (state_q == S_WR_FILTER) begin
                                    state_q <= S_WR_START;
                                end else if (state_q == S_WR_START) begin
                                    state_q <= S_POLL_DONE;
                                    polls_q <= '0;
                                end else begin
                                    state_q <= S_FINISH;
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                        default: ph_q <= PH_GAP;
                    endcase
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase

            if (go) begin
                if (is_poll) begin
                    if ((MAX_POLLS != 0) && (polls_q == PW'(MAX_POLLS))) begin
                        state_q <= S_IDLE;
                        ph_q    <= PH_GAP;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= AW'(1);
                        polls_q   <= polls_q + 1'b1;
                        ph_q      <= PH_ADDR;
                    end
                end else begin
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    awaddr_q  <= wr_addr;
                    wdata_q   <= wr_data;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    ph_q      <= PH_ADDR;
                end
            end
        end
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign error                 = error_q;
    assign last_status           = status_q;
    assign m_axi_control_awaddr  = awaddr_q;
    assign m_axi_control_awvalid = awvalid_q;
    assign m_axi_control_wdata   = wdata_q;
    assign m_axi_control_wvalid  = wvalid_q;
    assign m_axi_control_bready  = bready_q;
    assign m_axi_control_araddr  = araddr_q;
    assign m_axi_control_arvalid = arvalid_q;
    assign m_axi_control_rready  = rready_q;

endmodule

// File: tb/tb_filter_ctrl_master.sv
// tb_filter_ctrl_master: directed bench with an AXI4-Lite responder model
// that logs completed transactions and watches protocol rules.
module tb_filter_ctrl_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [26:0] kernel = '0;
    logic        busy, done, error;
    logic [31:0] last_status;
    logic [1:0]  awaddr, araddr;
    logic [31:0] wdata;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic        arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    filter_ctrl_master #(
        .AXI_CONTROL_DATA_WIDTH(32),
        .AXI_CONTROL_ADDR_WIDTH(2),
        .POLL_GAP(2),
        .MAX_POLLS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kernel(kernel),
        .busy(busy), .done(done), .error(error), .last_status(last_status),
        .m_axi_control_awaddr(awaddr), .m_axi_control_awvalid(awvalid),
        .m_axi_control_awready(awready), .m_axi_control_wdata(wdata),
        .m_axi_control_wvalid(wvalid), .m_axi_control_wready(wready),
        .m_axi_control_bresp(bresp), .m_axi_control_bvalid(bvalid),
        .m_axi_control_bready(bready), .m_axi_control_araddr(araddr),
        .m_axi_control_arvalid(arvalid), .m_axi_control_arready(arready),
        .m_axi_control_rdata(rdata), .m_axi_control_rresp(rresp),
        .m_axi_control_rvalid(rvalid), .m_axi_control_rready(rready)
    );

    int tests = 0;
    int fails = 0;

    // responder configuration (written by the stimulus process only)
    int          max_dly = 0;
    int          aw_fix = -1;
    int          w_fix = -1;
    int          inj_wr = 0;
    logic [31:0] stat[16];
    int          stat_n = 1;
    int          run_id = 0;

    // responder / monitor state (written by the responder/monitor only)
    int          seen_id = 0;
    int          stat_i = 0;
    int          wr_cnt = 0;
    int          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
    logic [1:0]  cur_wa = '0, cur_ra = '0;
    logic [31:0] cur_wd = '0;
    int          lk[256];
    int          la[256];
    logic [31:0] ld[256];
    int          ln = 0;
    int          viol = 0;
    int          done_cnt = 0;
    int          valid_cyc = 0;
    logic        p_awv = 0, p_wv = 0, p_arv = 0;
    logic [1:0]  p_awa = '0, p_ara = '0;
    logic [31:0] p_wd = '0;

    function automatic int pick(input int fix);
        if (fix >= 0) return fix;
        if (max_dly == 0) return 0;
        return int'($urandom_range(max_dly, 0));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            arready = 0; rvalid = 0; rresp = 0; rdata = 0;
            aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
        end else begin
            if (seen_id != run_id) begin
                seen_id = run_id; stat_i = 0; wr_cnt = 0;
            end
            if (!awvalid) begin
                awready = 0; aw_d = pick(aw_fix);
            end else if (!awready) begin
                if (aw_d == 0) begin awready = 1; cur_wa = awaddr; end
                else aw_d--;
            end
            if (!wvalid) begin
                wready = 0; w_d = pick(w_fix);
            end else if (!wready) begin
                if (w_d == 0) begin wready = 1; cur_wd = wdata; end
                else w_d--;
            end
            if (bvalid) begin
                bvalid = 0; bresp = 0;
            end else if (bready) begin
                if (b_d == 0) begin
                    bvalid = 1;
                    wr_cnt++;
                    bresp = (wr_cnt == inj_wr) ? 2'b10 : 2'b00;
                    if (ln < 256) begin
                        lk[ln] = 1; la[ln] = int'(cur_wa); ld[ln] = cur_wd; ln++;
                    end
                end else b_d--;
            end else b_d = pick(-1);
            if (!arvalid) begin
                arready = 0; ar_d = pick(-1);
            end else if (!arready) begin
                if (ar_d == 0) begin arready = 1; cur_ra = araddr; end
                else ar_d--;
            end
            if (rvalid) begin
                rvalid = 0;
            end else if (rready) begin
                if (r_d == 0) begin
                    rvalid = 1;
                    rdata = stat[(stat_i < stat_n) ? stat_i : stat_n - 1];
                    stat_i++;
                    if (ln < 256) begin
                        lk[ln] = 0; la[ln] = int'(cur_ra); ld[ln] = rdata; ln++;
                    end
                end else r_d--;
            end else r_d = pick(-1);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (arvalid || awvalid) valid_cyc++;
            if (arvalid && awvalid) viol++;
            if ((arvalid || rready) && (awvalid || wvalid || bready)) viol++;
            if (awvalid && p_awv && awaddr !== p_awa) viol++;
            if (wvalid && p_wv && wdata !== p_wd) viol++;
            if (arvalid && p_arv && araddr !== p_ara) viol++;
            if (awvalid && !p_awv && !(wvalid && !p_wv)) viol++;
        end
        p_awv = awvalid; p_wv = wvalid; p_arv = arvalid;
        p_awa = awaddr; p_wd = wdata; p_ara = araddr;
    end

    task automatic prep(input int md, input int afix, input int wfix, input int inj);
        max_dly = md; aw_fix = afix; w_fix = wfix; inj_wr = inj;
        run_id++;
    endtask

    task automatic kick(input logic [26:0] k);
        @(negedge clk);
        kernel = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy) begin
            fails++;
            $display("FAIL %s_timeout: busy=%0b after %0d cycles, want 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, error, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 00000000",
                     {busy, done, error, awvalid, wvalid, bready, arvalid, rready});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({last_status, wdata, awaddr, araddr} !== 36'h0) begin
            fails++;
            $display("FAIL reset_data: status=%h wdata=%h aw=%0d ar=%0d want 0",
                     last_status, wdata, awaddr, araddr);
        end
        tests++;
        if (busy !== 1'b0 || valid_cyc != 0) begin
            fails++;
            $display("FAIL reset_quiet: busy=%0b valid_cyc=%0d want 0/0", busy, valid_cyc);
        end
    endtask

    // full run with STATUS 0,1,1,1,2 and the given handshake delays
    task automatic test_full_run(input string name, input int md, input int afix,
                                 input int wfix, input logic [26:0] k);
        int lb, db, vb;
        int ek[8];
        int ea[8];
        logic [31:0] ed[8];
        stat[0] = 0; stat[1] = 1; stat[2] = 1; stat[3] = 1; stat[4] = 2; stat_n = 5;
        prep(md, afix, wfix, 0);
        lb = ln; db = done_cnt; vb = viol;
        ek = '{0, 1, 1, 0, 0, 0, 0, 1};
        ea = '{1, 2, 0, 1, 1, 1, 1, 0};
        ed = '{32'd0, {5'b0, k}, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd0};
        kick(k);
        wait_idle(name, 2000);
        repeat (3) @(negedge clk);
        tests++;
        if (ln - lb != 8) begin
            fails++;
            $display("FAIL %s_count: got %0d transactions want 8", name, ln - lb);
        end
        for (int i = 0; i < 8; i++) begin
            if (lb + i < ln) begin
                tests++;
                if (lk[lb+i] != ek[i] || la[lb+i] != ea[i] || ld[lb+i] !== ed[i]) begin
                    fails++;
                    $display("FAIL %s_txn%0d: got kind=%0d addr=%0d data=%h want kind=%0d addr=%0d data=%h",
                             name, i, lk[lb+i], la[lb+i], ld[lb+i], ek[i], ea[i], ed[i]);
                end
            end
        end
        tests++;
        if (done_cnt - db != 1 || error !== 1'b0 || last_status !== 32'd2) begin
            fails++;
            $display("FAIL %s_end: done=%0d error=%0b status=%h want 1/0/2",
                     name, done_cnt - db, error, last_status);
        end
        tests++;
        if (viol != vb) begin
            fails++;
            $display("FAIL %s_protocol: got %0d violations want 0", name, viol - vb);
        end
    endtask

    task automatic test_bresp_error();
        int lb, db, vc;
        stat[0] = 0; stat[1] = 2; stat_n = 2;
        prep(0, -1, -1, 2);
        lb = ln; db = done_cnt;
        kick(27'h0123456);
        wait_idle("berr", 500);
        tests++;
        if (error !== 1'b1 || busy !== 1'b0 || done_cnt != db) begin
            fails++;
            $display("FAIL berr_flags: error=%0b busy=%0b done=%0d want 1/0/0",
                     error, busy, done_cnt - db);
        end
        vc = valid_cyc;
        repeat (20) @(negedge clk);
        tests++;
        if (ln - lb != 3 || valid_cyc != vc) begin
            fails++;
            $display("FAIL berr_quiet: txns=%0d valid_cycles=%0d want 3/0",
                     ln - lb, valid_cyc - vc);
        end
        prep(0, -1, -1, 0);
        lb = ln; db = done_cnt;
        kick(27'h0000007);
        tests++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL berr_clear: error=%0b busy=%0b want 0/1", error, busy);
        end
        wait_idle("berr_rerun", 500);
        repeat (2) @(negedge clk);
        tests++;
        if (done_cnt - db != 1 || error !== 1'b0 || ln - lb != 5 ||
            last_status !== 32'd2) begin
            fails++;
            $display("FAIL berr_rerun: done=%0d error=%0b txns=%0d status=%h want 1/0/5/2",
                     done_cnt - db, error, ln - lb, last_status);
        end
    endtask

    task automatic test_poll_timeout();
        int lb, db, nreads;
        stat[0] = 0; stat[1] = 1; stat_n = 2;
        prep(1, -1, -1, 0);
        lb = ln; db = done_cnt;
        kick(27'h1555555);
        wait_idle("tmo", 2000);
        repeat (3) @(negedge clk);
        nreads = 0;
        for (int i = lb + 3; i < ln; i++)
            if (lk[i] == 0 && la[i] == 1 && ld[i] == 32'd1) nreads++;
        tests++;
        if (nreads != 8 || ln - lb != 11) begin
            fails++;
            $display("FAIL tmo_reads: got %0d status reads (%0d txns) want 8 (11)",
                     nreads, ln - lb);
        end
        tests++;
        if (error !== 1'b1 || busy !== 1'b0 || done_cnt != db) begin
            fails++;
            $display("FAIL tmo_flags: error=%0b busy=%0b done=%0d want 1/0/0",
                     error, busy, done_cnt - db);
        end
    endtask

    task automatic test_start_while_busy();
        int lb, db;
        logic [26:0] k1, k2;
        k1 = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        k2 = 27'h2AAAAAA;
        stat[0] = 0; stat[1] = 2; stat_n = 2;
        prep(0, -1, -1, 0);
        lb = ln; db = done_cnt;
        kick(k1);
        kernel = k2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start", 500);
        repeat (3) @(negedge clk);
        tests++;
        if (ln - lb != 5 || ld[lb+1] !== {5'b0, k1}) begin
            fails++;
            $display("FAIL busy_start_kernel: txns=%0d filter=%h want 5/%h",
                     ln - lb, ld[lb+1], {5'b0, k1});
        end
        tests++;
        if (done_cnt - db != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_start_runs: done=%0d busy=%0b want 1/0",
                     done_cnt - db, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int lb, vc;
        stat[0] = 0; stat[1] = 2; stat_n = 2;
        prep(2, -1, -1, 0);
        kick(27'h0000111);
        while (!awvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!awvalid) begin
            fails++;
            $display("FAIL rstmid_wait: awvalid=%0b after %0d cycles want 1", awvalid, n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_async: awvalid=%0b wvalid=%0b busy=%0b want 0/0/0",
                     awvalid, wvalid, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lb = ln; vc = valid_cyc;
        repeat (20) @(negedge clk);
        tests++;
        if (ln != lb || valid_cyc != vc || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_quiet: txns=%0d valid_cycles=%0d busy=%0b want 0/0/0",
                     ln - lb, valid_cyc - vc, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) stat[i] = '0;
        test_reset();
        test_full_run("basic", 0, -1, -1,
                      {3'd1, 3'd2, 3'd1, 3'd2, 3'd4, 3'd2, 3'd1, 3'd2, 3'd1});
        test_full_run("random", 5, -1, -1, 27'h3C0FFEE);
        test_full_run("wfirst", 0, 3, 0, 27'h1234567);
        test_bresp_error();
        test_poll_timeout();
        test_start_while_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
